cnt_seq_checker: RTL and testbench

Downstream monitor for the 3-bit sequence counter. It samples the counter's `{da,db,dc}` outputs on a strobe and checks each sample against the counter's defined next-state function. It acquires lock after a run of legal transitions, then flags and counts illegal transitions and counts completed counting cycles. It sits directly on the counter outputs, in the design and in the bench, as the self-checking stage.

---
 rtl/cnt_seq_pkg.sv | 28 ++
 rtl/cnt_seq_checker.sv | 94 +++++++++
 tb/tb_cnt_seq_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and the 3-bit sequence counter's next-state function,
// used by the checker and as the bench's reference model.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } cnt_state_e;

  localparam logic [2:0] CYCLE_START = 3'b110;

  function automatic logic [2:0] nxt_cnt(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'b000:  n = 3'b011;
      3'b001:  n = 3'b010;
      3'b010:  n = 3'b111;
      3'b011:  n = 3'b110;
      3'b100:  n = 3'b001;
      3'b101:  n = 3'b010;
      3'b110:  n = 3'b101;
      default: n = 3'b110;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnt_seq_checker.sv
// Monitors {da,db,dc} samples against nxt_cnt: acquires lock after LOCK_N
// legal transitions, then flags and counts illegal ones and counts cycles.
module cnt_seq_checker
  import cnt_seq_pkg::*;
#(
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [2:0]        cnt_in,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [2:0]        expected,
  output logic [1:0]        fsm_state
);

  cnt_state_e        r_state;
  logic [2:0]        r_prev;
  logic [3:0]        r_run;
  logic              r_locked;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_count;
  logic [WRAP_W-1:0] r_wrap_count;

  logic       w_match;
  logic [3:0] w_run_inc;

  assign w_match   = valid && (cnt_in == nxt_cnt(r_prev));
  assign w_run_inc = r_run + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_prev       <= 3'b000;
      r_run        <= 4'd0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid) begin
        r_prev <= cnt_in;
        case (r_state)
          StIdle: begin
            // First sample only seeds r_prev; nothing to compare against yet.
            r_state <= StAcquire;
            r_run   <= 4'd0;
          end
          StAcquire: begin
            if (w_match) begin
              r_run <= w_run_inc;
              if (w_run_inc == 4'(LOCK_N)) begin
                r_state  <= StLocked;
                r_locked <= 1'b1;
              end
            end else begin
              r_run <= 4'd0;
            end
          end
          StLocked: begin
            if (w_match) begin
              if (cnt_in == CYCLE_START) r_wrap_count <= r_wrap_count + 1'b1;
            end else begin
              r_err    <= 1'b1;
              r_state  <= StAcquire;
              r_locked <= 1'b0;
              r_run    <= 4'd0;
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            end
          end
          default: begin
            r_state  <= StIdle;
            r_locked <= 1'b0;
            r_run    <= 4'd0;
          end
        endcase
      end
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;
  assign expected   = nxt_cnt(r_prev);
  assign fsm_state  = r_state;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Scoreboard bench: the driver pushes hand-computed post-edge outputs per
// cycle, a monitor process pops and compares them on the falling edge.
module tb_cnt_seq_checker;
  import cnt_seq_pkg::*;

  localparam int unsigned LockN = 3;
  localparam int unsigned ErrW  = 2;
  localparam int unsigned WrapW = 2;

  logic             clk;
  logic             reset;
  logic             valid;
  logic [2:0]       cnt_in;
  logic             locked;
  logic             err;
  logic [ErrW-1:0]  err_count;
  logic [WrapW-1:0] wrap_count;
  logic [2:0]       expected;
  logic [1:0]       fsm_state;

  cnt_seq_checker #(
    .LOCK_N(LockN),
    .ERR_W (ErrW),
    .WRAP_W(WrapW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .cnt_in    (cnt_in),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .wrap_count(wrap_count),
    .expected  (expected),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       locked;
    logic       err;
    logic [1:0] errc;
    logic [1:0] wrap;
    logic [2:0] expd;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] prev_m = 3'b000;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SA = 2'd1;
  localparam logic [1:0] SL = 2'd2;

  task automatic chk(input string tag, input string fld, input logic [3:0] act,
                     input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, required %0h", tag, fld, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending entry compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "locked",     {3'b0, locked},      {3'b0, e.locked});
        chk(e.tag, "err",        {3'b0, err},         {3'b0, e.err});
        chk(e.tag, "err_count",  {2'b0, err_count},   {2'b0, e.errc});
        chk(e.tag, "wrap_count", {2'b0, wrap_count},  {2'b0, e.wrap});
        chk(e.tag, "expected",   {1'b0, expected},    {1'b0, e.expd});
        chk(e.tag, "fsm_state",  {2'b0, fsm_state},   {2'b0, e.st});
      end
    end
  end

  // Drive one cycle, then push the outputs required after that edge.
  task automatic step(input logic r, input logic v, input logic [2:0] c, input logic l,
                      input logic e, input logic [1:0] ec, input logic [1:0] w,
                      input logic [1:0] st, input string tag);
    exp_t x;
    reset  = r;
    valid  = v;
    cnt_in = c;
    @(posedge clk);
    #1;
    if (r)      prev_m = 3'b000;
    else if (v) prev_m = c;
    x.locked = l;
    x.err    = e;
    x.errc   = ec;
    x.wrap   = w;
    x.expd   = nxt_cnt(prev_m);
    x.st     = st;
    x.tag    = tag;
    sb_q.push_back(x);
  endtask

  initial begin
    logic [1:0] ec;
    logic [1:0] w;
    reset  = 1'b1;
    valid  = 1'b0;
    cnt_in = 3'b000;

    step(1, 0, 3'b000, 0, 0, 0, 0, SI, "reset");
    // Main cycle from 000: lock after the 101 sample, wrap on the final 110.
    step(0, 1, 3'b000, 0, 0, 0, 0, SA, "seed000");
    step(0, 1, 3'b011, 0, 0, 0, 0, SA, "acq011");
    step(0, 1, 3'b110, 0, 0, 0, 0, SA, "acq110");
    step(0, 1, 3'b101, 1, 0, 0, 0, SL, "lock101");
    step(0, 1, 3'b010, 1, 0, 0, 0, SL, "lk010");
    step(0, 1, 3'b111, 1, 0, 0, 0, SL, "lk111");
    step(0, 1, 3'b110, 1, 0, 0, 1, SL, "wrap1");
    step(0, 1, 3'b101, 1, 0, 0, 1, SL, "lk101");
    step(0, 1, 3'b111, 0, 1, 1, 1, SA, "err111");
    step(0, 0, 3'b000, 0, 0, 1, 1, SA, "errpulse");
    step(0, 1, 3'b110, 0, 0, 1, 1, SA, "reacq110");
    step(0, 1, 3'b101, 0, 0, 1, 1, SA, "reacq101");
    step(0, 1, 3'b010, 1, 0, 1, 1, SL, "relock");
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 3'(i * 5 + 3), 1, 0, 1, 1, SL, "hold");
    end
    step(0, 1, 3'b111, 1, 0, 1, 1, SL, "resume111");
    step(0, 1, 3'b110, 1, 0, 1, 2, SL, "wrap2");
    step(0, 1, 3'b101, 1, 0, 1, 2, SL, "lk101b");
    // Reset mid-LOCKED; the legal sample at this edge must be discarded.
    step(1, 1, 3'b010, 0, 0, 0, 0, SI, "midreset");
    // Off-cycle entry path.
    step(0, 1, 3'b100, 0, 0, 0, 0, SA, "ent100");
    step(0, 1, 3'b001, 0, 0, 0, 0, SA, "ent001");
    step(0, 1, 3'b010, 0, 0, 0, 0, SA, "ent010");
    step(0, 1, 3'b111, 1, 0, 0, 0, SL, "ent111");
    step(0, 1, 3'b110, 1, 0, 0, 1, SL, "entwrap");
    // Relock-then-error rounds: err_count saturates at 3, wrap rolls 3 -> 0.
    ec = 2'd0;
    w  = 2'd1;
    for (int r = 0; r < 5; r++) begin
      step(0, 1, 3'b101, 1, 0, ec, w, SL, "rnd101");
      if (ec != 2'd3) ec = ec + 2'd1;
      step(0, 1, 3'b111, 0, 1, ec, w, SA, "rnderr");
      step(0, 1, 3'b110, 0, 0, ec, w, SA, "rnd110");
      step(0, 1, 3'b101, 0, 0, ec, w, SA, "rnd101a");
      step(0, 1, 3'b010, 1, 0, ec, w, SL, "rndlock");
      step(0, 1, 3'b111, 1, 0, ec, w, SL, "rnd111");
      w = w + 2'd1;
      step(0, 1, 3'b110, 1, 0, ec, w, SL, "rndwrap");
    end
    valid = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
